// File: rtl/arb_pkg.sv
// arb_pkg: shared types and constants for the 8-way round-robin arbiter
// (rr_arb8_idx) and its priority search (rr_pick8).
//   arb_state_t : arbiter FSM state (ARB_IDLE, ARB_GRANT)
//   ARB_N       : number of requesters
//   ARB_IDX_W   : width of a requester index
package arb_pkg;

  localparam int ARB_N     = 8;
  localparam int ARB_IDX_W = 3;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arb8_idx_if.sv
// rr_arb8_idx_if: request/grant bundle between requesters and the arbiter.
//   req       : request vector, bit k = requester k        (master -> slave)
//   done      : current owner releases its grant           (master -> slave)
//   i         : granted requester index                    (slave -> master)
//   en        : grant valid                                (slave -> master)
//   busy      : arbiter is in GRANT (equals en)            (slave -> master)
//   timeout   : one-cycle pulse on forced release          (slave -> master)
//   dbg_state : arbiter FSM state, for observation only    (slave -> master)
//
// Handshake: en acts as "valid" for i; i is meaningful only while en=1.
// The owner (requester i) keeps the grant while en=1 until it raises done
// or drops req[i]; done is sampled only while en=1 and ignored otherwise.
// After every release en is low for exactly one cycle before the next grant.
interface rr_arb8_idx_if;

  logic [arb_pkg::ARB_N-1:0]     req;
  logic                          done;
  logic [arb_pkg::ARB_IDX_W-1:0] i;
  logic                          en;
  logic                          busy;
  logic                          timeout;
  arb_pkg::arb_state_t           dbg_state;

  modport master (
    output req,
    output done,
    input  i,
    input  en,
    input  busy,
    input  timeout,
    input  dbg_state
  );

  modport slave (
    input  req,
    input  done,
    output i,
    output en,
    output busy,
    output timeout,
    output dbg_state
  );

endinterface

// File: rtl/rr_pick8.sv
// rr_pick8: combinational rotate-priority encoder for 8 requesters.
// Searches req starting at last+1, wrapping modulo 8, and returns the first
// set bit. The previous winner (last) is checked last, giving it the
// lowest priority.
//   req    : request vector
//   last   : index of the previous winner
//   winner : index of the first set bit after last (0 when none)
//   any    : 1 when at least one request is set
module rr_pick8
  import arb_pkg::*;
(
  input  logic [ARB_N-1:0]     req,
  input  logic [ARB_IDX_W-1:0] last,
  output logic [ARB_IDX_W-1:0] winner,
  output logic                 any
);

  logic [ARB_IDX_W-1:0] idx;

  always_comb begin
    winner = '0;
    idx    = '0;
    any    = |req;
    // Walk from the farthest offset to the nearest so the nearest set bit
    // after last overwrites the others. Offset 8 wraps back onto last itself.
    for (int off = ARB_N - 1; off >= 0; off--) begin
      idx = last + ARB_IDX_W'(off + 1);
      if (req[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/rr_arb8_idx.sv
// rr_arb8_idx: registered round-robin arbiter for 8 requesters, emitting
// the winner as a binary index plus enable (feeds a 3-to-8 decoder).
// Optional feature macro: ARB_TIMEOUT_EN (forced release after HOLD_MAX
// cycles of en=1, flagged by a one-cycle timeout pulse).
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : rr_arb8_idx_if.slave (req, done in; i, en, busy, timeout,
//          dbg_state out)
// Parameters:
//   HOLD_MAX : max consecutive grant cycles with timeout built in (1..255)
//   CNT_W    : hold counter width, 2**CNT_W > HOLD_MAX
module rr_arb8_idx
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 8
) (
  input  logic          clk,
  input  logic          rst,
  rr_arb8_idx_if.slave  bus
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255 || (1 << CNT_W) <= HOLD_MAX) begin : g_param_check
    $error("rr_arb8_idx: illegal HOLD_MAX/CNT_W combination");
  end

  arb_state_t           state_q, state_d;
  logic [ARB_IDX_W-1:0] i_q, i_d;
  logic [ARB_IDX_W-1:0] last_q, last_d;
  logic                 to_q, to_d;
  logic [ARB_IDX_W-1:0] winner;
  logic                 any;
  logic                 rel;
  logic                 hold_expired;

  rr_pick8 u_pick (
    .req    (bus.req),
    .last   (last_q),
    .winner (winner),
    .any    (any)
  );

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign hold_expired = (cnt_q == CNT_W'(HOLD_MAX - 1));

  // Counts grant cycles already spent; cleared on every new grant.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ARB_IDLE) begin
      cnt_d = '0;
    end else if (rel) begin
      cnt_d = '0;
    end else if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign hold_expired = 1'b0;
`endif

  // done and a dropped request are checked together, so both at once still
  // produce a single release.
  assign rel = bus.done | ~bus.req[i_q] | hold_expired;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    last_d  = last_q;
    to_d    = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (any) begin
          state_d = ARB_GRANT;
          i_d     = winner;
        end
      end
      ARB_GRANT: begin
        if (rel) begin
          state_d = ARB_IDLE;
          last_d  = i_q;
          // Flag only releases caused solely by the hold limit.
          to_d    = hold_expired & ~bus.done & bus.req[i_q];
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      i_q     <= '0;
      last_q  <= ARB_IDX_W'(ARB_N - 1);
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      last_q  <= last_d;
      to_q    <= to_d;
    end
  end

  assign bus.i         = i_q;
  assign bus.en        = (state_q == ARB_GRANT);
  assign bus.busy      = (state_q == ARB_GRANT);
  assign bus.timeout   = to_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_rr_arb8_idx.sv
// tb_rr_arb8_idx: directed self-checking bench for rr_arb8_idx.
// Inputs change on the falling edge; outputs are checked on the falling
// edge after the rising edge that registers them.
module tb_rr_arb8_idx;

`ifdef ARB_TIMEOUT_EN
  localparam int HM = 4;
`else
  localparam int HM = 15;
`endif

  logic clk;
  logic rst;
  int   total;
  int   bad;

  rr_arb8_idx_if bus ();

  rr_arb8_idx #(
    .HOLD_MAX (HM),
    .CNT_W    (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [7:0] r, input logic d);
    bus.req  = r;
    bus.done = d;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [5:0] obs;
    drive(8'h00, 1'b0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      obs = {bus.busy, bus.timeout, bus.en, bus.i};
      total++;
      if (obs !== 6'b00_0_000) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got {busy,to,en,i}=%b want 000000", c, obs);
      end
    end
  endtask

  task automatic test_alternate();
    logic [3:0] obs;
    logic [2:0] exp_i [4];
    exp_i[0] = 3'd0; exp_i[1] = 3'd7; exp_i[2] = 3'd0; exp_i[3] = 3'd7;
    drive(8'b1000_0001, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      obs = {bus.en, bus.i};
      total++;
      if (obs !== {1'b1, exp_i[k]}) begin
        bad++;
        $display("FAIL alt_grant k=%0d got {en,i}=%b want %b", k, obs, {1'b1, exp_i[k]});
      end
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      total++;
      if (bus.en !== 1'b0) begin
        bad++;
        $display("FAIL alt_gap k=%0d got en=%b want 0", k, bus.en);
      end
    end
    // leave idle with last=7
    drive(8'h00, 1'b0);
    step();
  endtask

  task automatic test_latency_drop();
    logic [3:0] obs;
    // establish last=2
    drive(8'b0000_0100, 1'b0);
    step();
    obs = {bus.en, bus.i};
    total++;
    if (obs !== 4'b1_010) begin
      bad++;
      $display("FAIL lat_setup got {en,i}=%b want 1010", obs);
    end
    drive(8'h00, 1'b0);
    step();
    // cycle N: raise 2 and 5 with last=2
    drive(8'b0010_0100, 1'b0);
    step();
    obs = {bus.en, bus.i};
    total++;
    if (obs !== 4'b1_101) begin
      bad++;
      $display("FAIL lat_n1 got {en,i}=%b want 1101", obs);
    end
    // drop req[5]
    drive(8'b0000_0100, 1'b0);
    step();
    total++;
    if (bus.en !== 1'b0) begin
      bad++;
      $display("FAIL drop_release got en=%b want 0", bus.en);
    end
    step();
    obs = {bus.en, bus.i};
    total++;
    if (obs !== 4'b1_010) begin
      bad++;
      $display("FAIL drop_regrant got {en,i}=%b want 1010", obs);
    end
    // new requests during grant leave i untouched
    drive(8'hFF, 1'b0);
    step();
    obs = {bus.en, bus.i};
    total++;
    if (obs !== 4'b1_010) begin
      bad++;
      $display("FAIL grant_stable got {en,i}=%b want 1010", obs);
    end
    // simultaneous done and request drop: one release
    drive(8'b1111_1011, 1'b1);
    step();
    bus.done = 1'b0;
    total++;
    if (bus.en !== 1'b0) begin
      bad++;
      $display("FAIL done_drop got en=%b want 0", bus.en);
    end
    step();
    obs = {bus.en, bus.i};
    total++;
    if (obs !== 4'b1_011) begin
      bad++;
      $display("FAIL rotate_3 got {en,i}=%b want 1011", obs);
    end
  endtask

  task automatic test_reset_mid_grant();
    logic [4:0] obs;
    // granted i=3 here; assert reset away from any rising edge
    #1;
    rst = 1'b1;
    #1;
    obs = {bus.busy, bus.en, bus.i};
    total++;
    if (obs !== 5'b0_0_000) begin
      bad++;
      $display("FAIL async_rst got {busy,en,i}=%b want 00000", obs);
    end
    #1;
    rst = 1'b0;
    drive(8'hFF, 1'b0);
    step();
    obs = {1'b0, bus.en, bus.i};
    total++;
    if (obs !== 5'b0_1_000) begin
      bad++;
      $display("FAIL rst_first_grant got {en,i}=%b want 1000", obs[3:0]);
    end
    drive(8'h00, 1'b1);
    step();
    bus.done = 1'b0;
    // done while en=0 is ignored: a new request is still granted
    drive(8'b0001_0000, 1'b1);
    step();
    bus.done = 1'b0;
    obs = {1'b0, bus.en, bus.i};
    total++;
    if (obs !== 5'b0_1_100) begin
      bad++;
      $display("FAIL done_idle got {en,i}=%b want 1100", obs[3:0]);
    end
    // release; then grant 0 so last=0 for the hold test
    drive(8'b0000_0001, 1'b1);
    step();
    bus.done = 1'b0;
    step();
    drive(8'h00, 1'b0);
    step();
  endtask

  task automatic test_hold();
    logic [4:0] obs;
    drive(8'b0000_0010, 1'b0);
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < 4; c++) begin
      step();
      obs = {bus.timeout, bus.en, bus.i};
      total++;
      if (obs !== 5'b0_1_001) begin
        bad++;
        $display("FAIL hold_on c=%0d got {to,en,i}=%b want 01001", c, obs);
      end
    end
    step();
    obs = {bus.timeout, bus.en, 3'b000};
    total++;
    if (obs !== 5'b1_0_000) begin
      bad++;
      $display("FAIL hold_timeout got {to,en}=%b want 10", obs[4:3]);
    end
    step();
    obs = {bus.timeout, bus.en, bus.i};
    total++;
    if (obs !== 5'b0_1_001) begin
      bad++;
      $display("FAIL hold_regrant got {to,en,i}=%b want 01001", obs);
    end
`else
    for (int c = 0; c < 100; c++) begin
      step();
      obs = {bus.timeout, bus.en, bus.i};
      total++;
      if (obs !== 5'b0_1_001) begin
        bad++;
        $display("FAIL hold_persist c=%0d got {to,en,i}=%b want 01001", c, obs);
      end
    end
`endif
    drive(8'h00, 1'b0);
    step();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    drive(8'h00, 1'b0);
    test_reset();
    test_alternate();
    test_latency_drop();
    test_reset_mid_grant();
    test_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arb8_idx.md
Name: rr_arb8_idx

Overview:
- Registered round-robin arbiter for 8 requesters.
- Emits the winning requester as a 3-bit binary index plus an enable.
- Drives the i[2:0]/en inputs of the team's 3-to-8 decoder stage directly; the decoder turns the index into the one-hot grant.
- Holds each grant until the owner signals done, drops its request, or (optional) a hold timeout expires.

Parameters:
- HOLD_MAX, 15: max consecutive cycles a grant may be held when timeout is compiled in; legal 1..255.
- CNT_W, 8: width of the hold counter; must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request vector, bit k = requester k.
- done  input  1  current owner releases grant; sampled only while en=1.
- i  output  3  granted requester index, registered.
- en  output  1  grant valid, registered; 0 = no grant.
- busy  output  1  1 while in GRANT state (equals en).
- timeout  output  1  one-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (async, rst=1): i=3'd0, en=0, busy=0, timeout=0, state=IDLE, last=3'd7 (first search starts at requester 0), hold counter=0.
- States: IDLE and GRANT.
- IDLE:
  - If req==0, stay in IDLE; en=0 and i holds its last value.
  - Else pick the first set bit in req, searching last+1, last+2, … with modulo-8 wrap.
  - Next cycle: i=winner, en=1, state=GRANT, counter=0.
  - Latency: req rising in cycle N gives en=1 in cycle N+1.
- GRANT:
  - i is stable.
  - Release condition: done=1, OR req[i]=0, OR (timeout build) counter==HOLD_MAX-1.
  - On release: next cycle en=0, state=IDLE, last=i.
  - Otherwise counter increments, saturating.
- Gap rule: en is low for exactly one cycle between consecutive grants. IDLE re-arbitrates in that cycle, so a pending request is granted on the following cycle.
- Fairness: the same requester cannot win twice in a row while any other request is pending.
  - A lone requester re-wins after the one-cycle gap.
- Simultaneous done and req[i] drop: single release, no double-count.
- done while en=0: ignored.
- Request changes during GRANT: do not affect i; they are evaluated only in IDLE.
- Reset mid-grant: en drops to 0 asynchronously; last returns to 7.
- i is never X after reset. Consumers must qualify i with en (the decoder's disabled output applies while en=0).

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - The hold counter forces release after HOLD_MAX cycles with en=1.
  - timeout pulses 1 for the single cycle in which en falls because of the forced release.
  - The timed-out requester is rotated to lowest priority like a normal release.
- Undefined:
  - No counter logic; a grant persists until done or req[i]=0.
  - timeout tied to 0. Parameters remain declared but unused.

Decomposition:
- Shared package arb_pkg:
  - state enum {ARB_IDLE, ARB_GRANT}.
  - Constants ARB_N=8 and ARB_IDX_W=3.
- One natural sub-module, rr_pick8: combinational rotate-priority encoder taking req[7:0] and last[2:0], returning winner[2:0] and any.
  - Keeps the arbiter FSM separate from the search logic and is reusable by other 8-way stages.

Test Plan:
- Reset then req=8'b0000_0000 for 10 cycles -> en=0, i=0, busy=0, timeout=0 throughout.
- req=8'b1000_0001 held, pulse done for 1 cycle whenever en=1 -> grants alternate i=0, 7, 0, 7, each separated by exactly one en=0 cycle.
- req=8'b0010_0100 with last=2, raised in cycle N -> en=1, i=5 in cycle N+1; drop req[5] -> en=0 next cycle; then i=2, en=1.
- During a grant to i=3, assert rst for 1 cycle mid-grant -> en falls without waiting for clk; after release, req=8'hFF -> first grant i=0.
- ARB_TIMEOUT_EN, HOLD_MAX=4, req=8'b0000_0010 held, done=0 -> en high exactly 4 cycles, timeout=1 on the en-fall cycle, 1-cycle gap, regrant i=1.
- Without the macro, same stimulus -> en stays 1 for 100 cycles, timeout stays 0.
